// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, fetch FSM state type and the fetch-address legality rule
// for the RV32 fetch stage.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT      = 32'h0000_0004;
  localparam logic [31:0] IMEM_MAX_ADDR_DEFAULT = 32'd10000;
  localparam logic [31:0] INST_NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // A fetch target is legal when it is word-aligned and inside instruction memory.
  function automatic logic is_legal_fetch(input logic [31:0] addr,
                                          input logic [31:0] max_addr);
    return (addr[1:0] == 2'b00) && (addr <= max_addr);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: control from the core, the instruction memory read port,
// and the registered fetch output towards decode/execute.
interface pc_fetch_unit_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        jalr_sel;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        inst_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  // Fetch unit side: drives the memory address and the fetch output register.
  modport master (
    input  stall,
    input  redirect,
    input  redirect_target,
    input  jalr_sel,
    output imem_addr,
    input  imem_inst,
    output inst_o,
    output pc_o,
    output pc_plus4_o,
    output inst_valid,
    output fault,
    output fault_pc,
    output fetch_cnt
  );

  // Core / memory side: supplies control and the instruction word.
  modport slave (
    output stall,
    output redirect,
    output redirect_target,
    output jalr_sel,
    input  imem_addr,
    output imem_inst,
    input  inst_o,
    input  pc_o,
    input  pc_plus4_o,
    input  inst_valid,
    input  fault,
    input  fault_pc,
    input  fetch_cnt
  );

endinterface

// File: rtl/pc_fetch_unit_next.sv
// Next-PC selection: redirect target (bit 0 dropped for JALR) or pc+4, plus
// the legality verdict for whichever candidate was chosen.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter logic [31:0] IMEM_MAX_ADDR = IMEM_MAX_ADDR_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        jalr_sel,
  output logic [31:0] candidate,
  output logic        legal
);

  logic [31:0] target_adj;

  // Pick the candidate and judge it; pc+4 wraps naturally at 2^32.
  always_comb begin
    target_adj = redirect_target;
    if (jalr_sel) begin
      target_adj[0] = 1'b0;
    end
    candidate = redirect ? target_adj : (pc + 32'd4);
    legal     = is_legal_fetch(candidate, IMEM_MAX_ADDR);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage of the single-cycle RV32 core: holds the PC, addresses the
// instruction memory combinationally and registers word + PC for decode.
// Illegal fetch targets park the unit in a terminal FAULT state.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter logic [31:0] IMEM_MAX_ADDR = IMEM_MAX_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc_p0;
  logic [31:0]  inst_p1;
  logic [31:0]  pc_p1;
  logic [31:0]  pc_plus4_p1;
  logic         vld_p1;
  logic         fault_q;
  logic [31:0]  fault_pc_q;
  logic [31:0]  fetch_cnt_q;
  logic [31:0]  candidate;
  logic         legal;

  pc_next_logic #(
    .IMEM_MAX_ADDR (IMEM_MAX_ADDR)
  ) u_next (
    .pc              (pc_p0),
    .redirect        (bus.redirect),
    .redirect_target (bus.redirect_target),
    .jalr_sel        (bus.jalr_sel),
    .candidate       (candidate),
    .legal           (legal)
  );

  // Fetch FSM: owns pc, the fetch output register, the fault record and the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_p0       <= RESET_PC;
      inst_p1     <= 32'd0;
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd4;
      vld_p1      <= 1'b0;
      fault_q     <= 1'b0;
      fault_pc_q  <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          vld_p1 <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          if (bus.redirect && !legal) begin
            state      <= FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= candidate;
            vld_p1     <= 1'b0;
          end else if (bus.redirect) begin
            // Word fetched this cycle is wrong-path: flush it, stall or not.
            pc_p0  <= candidate;
            vld_p1 <= 1'b0;
          end else if (bus.stall) begin
            vld_p1 <= vld_p1;
          end else begin
            // Deliver the current word even if the following address is illegal.
            inst_p1     <= bus.imem_inst;
            pc_p1       <= pc_p0;
            pc_plus4_p1 <= candidate;
            vld_p1      <= 1'b1;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (legal) begin
              pc_p0 <= candidate;
            end else begin
              state      <= FAULT;
              fault_q    <= 1'b1;
              fault_pc_q <= candidate;
            end
          end
        end
        FAULT: begin
          vld_p1 <= 1'b0;
        end
        default: begin
          state  <= FAULT;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Memory address follows pc directly; the rest are straight register outputs.
  always_comb begin
    bus.imem_addr  = pc_p0;
    bus.inst_o     = inst_p1;
    bus.pc_o       = pc_p1;
    bus.pc_plus4_o = pc_plus4_p1;
    bus.inst_valid = vld_p1;
    bus.fault      = fault_q;
    bus.fault_pc   = fault_pc_q;
    bus.fetch_cnt  = fetch_cnt_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small instruction-memory model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic xinj = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [0:2500];

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; xinj forces X to probe non-propagation.
  always_comb begin
    if (xinj) begin
      bus.imem_inst = 32'hxxxx_xxxx;
    end else if (bus.imem_addr <= 32'd10000) begin
      bus.imem_inst = mem[bus.imem_addr[13:2]];
    end else begin
      bus.imem_inst = 32'hxxxx_xxxx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2501; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 4);
    mem[1] = 32'h0011_9237;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'd0;
    bus.jalr_sel = 1'b0;

    // Reset and boot
    #1 rst = 1'b1;
    xinj = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst_o, 32'd0);
    check("rst_pc_o", bus.pc_o, 32'd0);
    check("rst_pc4", bus.pc_plus4_o, 32'd4);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_fault_pc", bus.fault_pc, 32'd0);
    check("rst_cnt", bus.fetch_cnt, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h4);
    rst = 1'b0;
    tick();
    check("boot_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("boot_addr", bus.imem_addr, 32'h4);
    check("boot_inst_noX", bus.inst_o, 32'd0);
    xinj = 1'b0;
    tick();
    check("f1_inst", bus.inst_o, 32'h0011_9237);
    check("f1_pc", bus.pc_o, 32'h4);
    check("f1_pc4", bus.pc_plus4_o, 32'h8);
    check("f1_valid", {31'd0, bus.inst_valid}, 32'd1);

    // Sequential fetch and stall
    tick();
    check("f2_pc", bus.pc_o, 32'h8);
    tick();
    check("f3_pc", bus.pc_o, 32'hC);
    check("f3_inst", bus.inst_o, 32'hC0DE_000C);
    tick();
    check("f4_pc", bus.pc_o, 32'h10);
    check("f4_cnt", bus.fetch_cnt, 32'd4);
    bus.stall = 1'b1;
    xinj = 1'b1;
    tick();
    tick();
    check("stall_pc", bus.pc_o, 32'h10);
    check("stall_inst", bus.inst_o, 32'hC0DE_0010);
    check("stall_pc4", bus.pc_plus4_o, 32'h14);
    check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("stall_cnt", bus.fetch_cnt, 32'd4);
    check("stall_addr", bus.imem_addr, 32'h14);
    bus.stall = 1'b0;
    xinj = 1'b0;

    // Branch redirect overriding stall
    repeat (6) tick();
    check("pre_br_addr", bus.imem_addr, 32'h2C);
    check("pre_br_cnt", bus.fetch_cnt, 32'd10);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h12C;
    bus.stall = 1'b1;
    xinj = 1'b1;
    tick();
    check("br_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("br_addr", bus.imem_addr, 32'h12C);
    check("br_cnt", bus.fetch_cnt, 32'd10);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    xinj = 1'b0;
    tick();
    check("br_pc", bus.pc_o, 32'h12C);
    check("br_inst", bus.inst_o, 32'hC0DE_012C);
    check("br_valid2", {31'd0, bus.inst_valid}, 32'd1);
    check("br_cnt2", bus.fetch_cnt, 32'd11);

    // JALR alignment, then misaligned JALR fault
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h1F9;
    bus.jalr_sel = 1'b1;
    tick();
    check("jalr_addr", bus.imem_addr, 32'h1F8);
    check("jalr_fault", {31'd0, bus.fault}, 32'd0);
    bus.redirect = 1'b0;
    bus.jalr_sel = 1'b0;
    tick();
    check("jalr_pc", bus.pc_o, 32'h1F8);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h1FA;
    bus.jalr_sel = 1'b1;
    tick();
    check("jf_fault", {31'd0, bus.fault}, 32'd1);
    check("jf_fault_pc", bus.fault_pc, 32'h1FA);
    check("jf_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("jf_addr", bus.imem_addr, 32'h1FC);
    bus.jalr_sel = 1'b0;
    bus.redirect_target = 32'h100;
    for (int k = 0; k < 5; k++) begin
      bus.stall = k[0];
      tick();
      check("fault_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("fault_hold_pc", bus.fault_pc, 32'h1FA);
      check("fault_hold_addr", bus.imem_addr, 32'h1FC);
    end
    check("fault_hold_cnt", bus.fetch_cnt, 32'd12);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;

    // Async reset mid-fault, between edges
    #3 rst = 1'b1;
    #1;
    check("ar_fault", {31'd0, bus.fault}, 32'd0);
    check("ar_addr", bus.imem_addr, 32'h4);
    check("ar_cnt", bus.fetch_cnt, 32'd0);
    check("ar_fault_pc", bus.fault_pc, 32'd0);
    tick();
    rst = 1'b0;

    // Redirect beyond end of memory
    tick();
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h2714;
    tick();
    check("rng_fault", {31'd0, bus.fault}, 32'd1);
    check("rng_fault_pc", bus.fault_pc, 32'h2714);
    check("rng_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rng_addr", bus.imem_addr, 32'h4);
    bus.redirect = 1'b0;

    // Sequential fetch off the end of memory
    #3 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h2710;
    tick();
    check("end_addr", bus.imem_addr, 32'h2710);
    check("end_fault0", {31'd0, bus.fault}, 32'd0);
    bus.redirect = 1'b0;
    tick();
    check("end_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("end_pc", bus.pc_o, 32'h2710);
    check("end_inst", bus.inst_o, 32'hC0DE_2710);
    check("end_pc4", bus.pc_plus4_o, 32'h2714);
    check("end_fault", {31'd0, bus.fault}, 32'd1);
    check("end_fault_pc", bus.fault_pc, 32'h2714);
    check("end_cnt", bus.fetch_cnt, 32'd1);
    tick();
    check("end_valid2", {31'd0, bus.inst_valid}, 32'd0);
    check("end_cnt2", bus.fetch_cnt, 32'd1);
    check("end_addr2", bus.imem_addr, 32'h2710);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory in the single-cycle RV32 core. It holds the PC and drives the instruction memory's combinational read address. It registers the returned word plus its PC into a fetch output register for decode/execute. It also handles stall, redirect (branch, JAL, JALR), and halting on illegal fetch targets.

Parameters:
RESET_PC, 32'h0000_0004, first fetch address after reset; must be word-aligned and <= IMEM_MAX_ADDR.
IMEM_MAX_ADDR, 32'd10000, highest legal byte address of instruction memory.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and fetch output register
redirect  in  1  take redirect_target this cycle (taken branch, JAL, JALR)
redirect_target  in  32  byte address of new PC
jalr_sel  in  1  redirect is a JALR: clear bit 0 of target before use
imem_addr  out  32  read address to instruction memory (= pc, combinational)
imem_inst  in  32  instruction word from instruction memory, same cycle
inst_o  out  32  registered instruction
pc_o  out  32  PC of inst_o
pc_plus4_o  out  32  pc_o + 4, modulo 2^32 (link value)
inst_valid  out  1  inst_o is a real instruction, not a bubble
fault  out  1  sticky illegal-fetch flag
fault_pc  out  32  offending target address
fetch_cnt  out  32  count of valid instructions delivered

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=BOOT, inst_o=0, pc_o=0, pc_plus4_o=4, inst_valid=0, fault=0, fault_pc=0, fetch_cnt=0.
- States and transitions:
  - BOOT: one cycle, outputs bubble, pc unchanged; then go to RUN.
  - RUN: normal fetch.
  - FAULT: terminal; exit only via rst.
- Next-PC candidate:
  - With redirect: redirect_target, with bit 0 cleared when jalr_sel=1.
  - Otherwise: pc+4, modulo 2^32.
- Legality check on the candidate: legal only if candidate[1:0]==0 and candidate <= IMEM_MAX_ADDR. pc never holds an illegal value.
- RUN, per posedge, priority top to bottom:
  1. redirect=1 with illegal candidate: go to FAULT, fault=1, fault_pc=candidate, inst_valid=0, pc held.
  2. redirect=1 with legal candidate: pc=candidate, inst_valid=0 (the word fetched this cycle is wrong-path and is flushed). One-cycle bubble. Overrides stall.
  3. stall=1: pc, inst_o, pc_o, pc_plus4_o, inst_valid and fetch_cnt all held.
  4. Sequential with illegal pc+4 (end of memory or wrap): go to FAULT, fault_pc=pc+4. The current word is still delivered with inst_valid=1.
  5. Sequential with legal pc+4: inst_o=imem_inst, pc_o=pc, pc_plus4_o=pc+4, inst_valid=1, pc=pc+4.
- fetch_cnt increments on every edge where inst_valid is written 1; it wraps at 2^32.
- FAULT: inst_valid=0 on the first FAULT edge and thereafter. fault and fault_pc are held. redirect and stall are ignored.
- Latency: a word at address A appears on inst_o one edge after pc==A, when not stalled or redirected.
- imem_inst is sampled only in RUN, non-stalled, non-redirected cycles. An X/Z value at any other time must not propagate.

Decomposition:
- cpu_pkg holds:
  - constants: RESET_PC default, IMEM_MAX_ADDR, INST_NOP (32'h0000_0013);
  - state typedef fetch_state_t {BOOT, RUN, FAULT};
  - function is_legal_fetch(addr).
- One combinational sub-module, pc_next_logic: inputs pc, redirect, redirect_target, jalr_sel; outputs candidate and legal.

Test Plan:
1. Reset and boot: hold rst 3 cycles, preload word 0x4 = 0x00119237. After release: imem_addr=0x4, first edge inst_valid=0, second edge inst_o=0x00119237, pc_o=0x4, pc_plus4_o=0x8.
2. Sequential fetch and stall: 4 free cycles give pc_o 4,8,12,16 and fetch_cnt=4. Then stall=1 for 2 cycles: all outputs constant, fetch_cnt=4.
3. Branch redirect: at pc=0x2C, redirect=1, target=0x12C, with stall=1 at the same time. Next edge: inst_valid=0, imem_addr=0x12C. Following edge: pc_o=0x12C, inst_valid=1.
4. JALR alignment: target 0x1F9 with jalr_sel=1 gives pc=0x1F8, fault=0. Then target 0x1FA with jalr_sel=1 gives fault=1, fault_pc=0x1FA, and inst_valid=0 for 5 further cycles despite redirects.
5. Range and end of memory:
   - redirect to 0x2714 → fault_pc=0x2714.
   - Separately, sequential fetch from 0x2710: word at 0x2710 delivered valid, then FAULT with fault_pc=0x2714.
6. Async reset mid-fault: assert rst between clock edges while in FAULT. fault=0, pc=0x4, fetch_cnt=0 immediately, with no clock edge required.
